nwc_mem_loader: RTL and testbench

//  Synthesizable preload/readback engine for the banked NTT coefficient memory. It accepts a

---
 rtl/nwc_pkg.sv | 25 ++
 rtl/nwc_skid_buf.sv | 76 +++++++
 rtl/nwc_mem_loader.sv | 188 ++++++++++++++++++
 tb/tb_nwc_mem_loader.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nwc_pkg.sv
// Package shared by the coefficient memory loader and its drain skid buffer.
//  - loader_state_e : loader FSM states
//  - DEF_D_WIDTH    : default coefficient width
//  - mod_reduce1    : single conditional subtract (x >= q ? x - q : x)
package nwc_pkg;

    localparam int DEF_D_WIDTH = 32;
    // Widest coefficient the reduce helper handles. Callers zero-extend into it.
    localparam int RED_W       = 64;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        KICK  = 3'd2,
        RUN   = 3'd3,
        DRAIN = 3'd4
    } loader_state_e;

    // One subtract is enough because inputs are assumed to be < 2*q.
    function automatic logic [RED_W-1:0] mod_reduce1(input logic [RED_W-1:0] x,
                                                     input logic [RED_W-1:0] q);
        return (x >= q) ? (x - q) : x;
    endfunction

endpackage

// File: rtl/nwc_skid_buf.sv
// 2-entry FIFO on the drain path of the loader.
//  clk, rst    : clock, synchronous active-high reset (drops held data)
//  push        : write push_data this cycle (caller guarantees space)
//  push_data   : incoming word
//  out_ready   : downstream accepts the head this cycle
//  out_valid   : head entry is valid
//  out_data    : head entry
//  count       : entries held (0..2), used by the caller for read credit
module nwc_skid_buf
#(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         out_ready,
    output logic         out_valid,
    output logic [W-1:0] out_data,
    output logic [1:0]   count
);

    logic [1:0]   count_q, count_d;
    logic [W-1:0] d0_q, d0_d;   // head
    logic [W-1:0] d1_q, d1_d;   // second entry
    logic         pop;

    always_comb begin
        pop     = (count_q != 2'd0) && out_ready;
        count_d = count_q;
        d0_d    = d0_q;
        d1_d    = d1_q;
        case ({push, pop})
            2'b10: begin
                if (count_q == 2'd0) begin
                    d0_d    = push_data;
                    count_d = 2'd1;
                end else if (count_q == 2'd1) begin
                    d1_d    = push_data;
                    count_d = 2'd2;
                end
            end
            2'b01: begin
                d0_d    = d1_q;
                count_d = count_q - 2'd1;
            end
            2'b11: begin
                // Head leaves while a new word arrives: occupancy unchanged.
                if (count_q == 2'd1) begin
                    d0_d = push_data;
                end else begin
                    d0_d = d1_q;
                    d1_d = push_data;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= 2'd0;
            d0_q    <= '0;
            d1_q    <= '0;
        end else begin
            count_q <= count_d;
            d0_q    <= d0_d;
            d1_q    <= d1_d;
        end
    end

    assign out_valid = (count_q != 2'd0);
    assign out_data  = d0_q;
    assign count     = count_q;

endmodule

// File: rtl/nwc_mem_loader.sv
// Preload/readback engine for the banked NTT coefficient memory.
// Streams BN*MA coefficients into the banks (coefficient n -> bank n%BN, addr n/BN),
// kicks the NTT core, waits for DONE, then drains the banks bank-major onto an
// AXI-style output stream.
//  clk, rst                          : clock, synchronous active-high reset
//  modulus                           : prime q, static while busy
//  start_load                        : begin a load (IDLE only)
//  in_valid/in_ready/in_data         : coefficient input stream
//  mem_wr_en/_bank/_addr/_data       : memory write port (same-cycle as the accepted beat)
//  ntt_start                         : one-cycle kick to the core
//  core_done                         : core finished (honoured in RUN only)
//  mem_rd_en/_bank/_addr, mem_rd_data: memory read port, data one cycle after the strobe
//  out_valid/out_ready/out_data      : drained coefficient stream
//  range_err                         : sticky, some accepted input was >= modulus
//  busy                              : not idle
//  drain_done                        : pulse the cycle after the last output beat
module nwc_mem_loader
    import nwc_pkg::*;
#(
    parameter  int D_WIDTH = DEF_D_WIDTH,
    parameter  int BN      = 16,
    parameter  int MA      = 64,
    parameter  int REDUCE  = 1,
    localparam int ADDR_W  = $clog2(MA),
    localparam int BANK_W  = $clog2(BN)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [D_WIDTH-1:0] modulus,
    input  logic               start_load,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [D_WIDTH-1:0] in_data,
    output logic               mem_wr_en,
    output logic [BANK_W-1:0]  mem_wr_bank,
    output logic [ADDR_W-1:0]  mem_wr_addr,
    output logic [D_WIDTH-1:0] mem_wr_data,
    output logic               ntt_start,
    input  logic               core_done,
    output logic               mem_rd_en,
    output logic [BANK_W-1:0]  mem_rd_bank,
    output logic [ADDR_W-1:0]  mem_rd_addr,
    input  logic [D_WIDTH-1:0] mem_rd_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [D_WIDTH-1:0] out_data,
    output logic               range_err,
    output logic               busy,
    output logic               drain_done
);

    localparam int              N_W    = BANK_W + ADDR_W;
    localparam logic [N_W-1:0]  N_LAST = N_W'(BN * MA - 1);

    loader_state_e  state_q, state_d;
    logic [N_W-1:0] n_q, n_d;             // load beat index
    logic [N_W-1:0] rd_cnt_q, rd_cnt_d;   // drain read index, {bank, addr}
    logic           rd_all_q, rd_all_d;   // every read of this drain issued
    logic           rd_pend_q, rd_pend_d; // read in flight, data lands this cycle
    logic [N_W-1:0] out_cnt_q, out_cnt_d; // drain beats accepted
    logic           range_err_q, range_err_d;
    logic           drain_done_q, drain_done_d;

    logic           load_go;
    logic           beat_acc;
    logic           in_ge_q;
    logic           out_pop;
    logic           last_pop;
    logic [1:0]     skid_cnt;
    logic [2:0]     occ_next;
    logic [D_WIDTH-1:0] reduced;

    assign load_go  = (state_q == IDLE) && start_load;
    assign beat_acc = in_valid && in_ready;
    assign in_ge_q  = (in_data >= modulus);
    assign out_pop  = out_valid && out_ready;
    assign last_pop = (state_q == DRAIN) && out_pop && (out_cnt_q == N_LAST);
    assign reduced  = D_WIDTH'(mod_reduce1(RED_W'(in_data), RED_W'(modulus)));

    // Skid occupancy once the in-flight word lands and this cycle's pop leaves.
    // A new read is allowed only while that stays below 2, so a stalled
    // consumer can never overflow the buffer; with out_ready=1 it stays at 1
    // and a read issues every cycle.
    assign occ_next = 3'(skid_cnt) + 3'(rd_pend_q) - 3'(out_pop);

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start_load) state_d = LOAD;
            LOAD:    if (beat_acc && (n_q == N_LAST)) state_d = KICK;
            KICK:    state_d = RUN;
            RUN:     if (core_done) state_d = DRAIN;   // start_load is ignored here
            DRAIN:   if (last_pop) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        in_ready  = (state_q == LOAD);
        mem_wr_en = (state_q == LOAD) && in_valid;
        ntt_start = (state_q == KICK);
        busy      = (state_q != IDLE);
        mem_rd_en = (state_q == DRAIN) && !rd_all_q && (occ_next < 3'd2);
    end

    // ---------------- datapath ----------------
    assign mem_wr_bank = n_q[BANK_W-1:0];
    assign mem_wr_addr = n_q[BANK_W +: ADDR_W];
    assign mem_wr_data = (REDUCE != 0 && in_ge_q) ? reduced : in_data;

    // Bank-major drain: address is the fast-moving field.
    assign mem_rd_addr = rd_cnt_q[ADDR_W-1:0];
    assign mem_rd_bank = rd_cnt_q[ADDR_W +: BANK_W];

    always_comb begin
        n_d          = n_q;
        range_err_d  = range_err_q;
        rd_cnt_d     = rd_cnt_q;
        rd_all_d     = rd_all_q;
        rd_pend_d    = mem_rd_en;
        out_cnt_d    = out_cnt_q;
        drain_done_d = last_pop;

        if (load_go) begin
            n_d         = '0;
            range_err_d = 1'b0;
        end else if (beat_acc) begin
            // BN*MA is a power of two, so the index wraps to 0 on its own.
            n_d = n_q + 1'b1;
            if (in_ge_q) range_err_d = 1'b1;
        end

        if (state_q != DRAIN) begin
            rd_cnt_d  = '0;
            rd_all_d  = 1'b0;
            out_cnt_d = '0;
        end else begin
            if (mem_rd_en) begin
                rd_cnt_d = rd_cnt_q + 1'b1;
                if (rd_cnt_q == N_LAST) rd_all_d = 1'b1;
            end
            if (out_pop) out_cnt_d = out_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            n_q          <= '0;
            range_err_q  <= 1'b0;
            rd_cnt_q     <= '0;
            rd_all_q     <= 1'b0;
            rd_pend_q    <= 1'b0;
            out_cnt_q    <= '0;
            drain_done_q <= 1'b0;
        end else begin
            n_q          <= n_d;
            range_err_q  <= range_err_d;
            rd_cnt_q     <= rd_cnt_d;
            rd_all_q     <= rd_all_d;
            rd_pend_q    <= rd_pend_d;
            out_cnt_q    <= out_cnt_d;
            drain_done_q <= drain_done_d;
        end
    end

    assign range_err  = range_err_q;
    assign drain_done = drain_done_q;

    nwc_skid_buf #(.W(D_WIDTH)) u_skid (
        .clk       (clk),
        .rst       (rst),
        .push      (rd_pend_q),
        .push_data (mem_rd_data),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .count     (skid_cnt)
    );

endmodule

// File: tb/tb_nwc_mem_loader.sv
module tb_nwc_mem_loader;

    localparam int BN = 4;
    localparam int MA = 4;
    localparam int N  = BN * MA;

    typedef logic [31:0] word_q_t[$];

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] modulus = 32'd17;
    logic        start_load = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_data = '0;
    logic        mem_wr_en;
    logic [1:0]  mem_wr_bank, mem_wr_addr;
    logic [31:0] mem_wr_data;
    logic        ntt_start;
    logic        core_done = 1'b0;
    logic        mem_rd_en;
    logic [1:0]  mem_rd_bank, mem_rd_addr;
    logic [31:0] mem_rd_data = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_data;
    logic        range_err, busy, drain_done;

    nwc_mem_loader #(.D_WIDTH(32), .BN(BN), .MA(MA), .REDUCE(1)) dut (
        .clk(clk), .rst(rst), .modulus(modulus), .start_load(start_load),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .mem_wr_en(mem_wr_en), .mem_wr_bank(mem_wr_bank), .mem_wr_addr(mem_wr_addr),
        .mem_wr_data(mem_wr_data), .ntt_start(ntt_start), .core_done(core_done),
        .mem_rd_en(mem_rd_en), .mem_rd_bank(mem_rd_bank), .mem_rd_addr(mem_rd_addr),
        .mem_rd_data(mem_rd_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .range_err(range_err), .busy(busy), .drain_done(drain_done)
    );

    always #5 clk = ~clk;

    // Banked memory the loader drives (environment, not the reference).
    logic [31:0] env_mem [N];
    always @(posedge clk) begin
        if (!rst && mem_wr_en) env_mem[int'(mem_wr_bank)*MA + int'(mem_wr_addr)] <= mem_wr_data;
        if (mem_rd_en) mem_rd_data <= env_mem[int'(mem_rd_bank)*MA + int'(mem_rd_addr)];
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int          m_k = 0;
    bit          m_loading = 0, m_busy = 0, m_kick = 0, m_running = 0;
    bit          m_draining = 0, m_dd = 0, m_range = 0, prev_stall = 0;
    logic [31:0] m_mem [N];
    logic [31:0] exp_q[$];
    logic [31:0] got_q[$];
    int          acc_cyc[$];
    int          cyc = 0, done_cyc = 0, first_valid_cyc = -1;
    int          kick_cnt = 0, dd_cnt = 0, wr_cnt = 0;
    bit          chk_on = 0;
    int          ready_pct = 100;

    always @(posedge clk) begin
        #1;
        out_ready = ($urandom_range(0, 99) < ready_pct);
    end

    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            m_k = 0; m_loading = 0; m_busy = 0; m_kick = 0; m_running = 0;
            m_draining = 0; m_dd = 0; m_range = 0; prev_stall = 0;
            exp_q.delete();
        end else if (chk_on) begin
            bit nk, ndd;
            logic [31:0] e;
            nk = 0; ndd = 0;
            chk("busy", busy, m_busy);
            chk("in_ready", in_ready, m_loading);
            chk("ntt_start", ntt_start, m_kick);
            chk("drain_done", drain_done, m_dd);
            chk("range_err", range_err, m_range);
            if (ntt_start) kick_cnt++;
            if (drain_done) dd_cnt++;

            if (in_valid && m_loading) begin
                e = (in_data >= modulus) ? in_data - modulus : in_data;
                chk("wr_en", mem_wr_en, 1);
                chk("wr_bank", mem_wr_bank, m_k % BN);
                chk("wr_addr", mem_wr_addr, m_k / BN);
                chk("wr_data", mem_wr_data, e);
                m_mem[(m_k % BN)*MA + m_k / BN] = e;
                if (in_data >= modulus) m_range = 1;
                m_k++; wr_cnt++;
                if (m_k == N) begin m_k = 0; m_loading = 0; nk = 1; end
            end else begin
                chk("wr_idle", mem_wr_en, 0);
            end

            if (start_load && !m_busy) begin
                m_busy = 1; m_loading = 1; m_k = 0; m_range = 0;
            end

            if (!m_draining) chk("rd_idle", mem_rd_en, 0);

            if (core_done && m_running) begin
                for (int b = 0; b < BN; b++)
                    for (int a = 0; a < MA; a++) exp_q.push_back(m_mem[b*MA + a]);
                m_running = 0; m_draining = 1; done_cyc = cyc;
            end

            if (prev_stall) chk("out_hold", out_valid, 1);
            if (out_valid) begin
                if (first_valid_cyc < 0) first_valid_cyc = cyc;
                if (exp_q.size() == 0) chk("out_spurious", out_valid, 0);
                else chk("out_data", out_data, exp_q[0]);
                if (out_ready) begin
                    if (exp_q.size() > 0) void'(exp_q.pop_front());
                    got_q.push_back(out_data);
                    acc_cyc.push_back(cyc);
                    if (exp_q.size() == 0 && m_draining) begin
                        m_draining = 0; m_busy = 0; ndd = 1;
                    end
                end
            end
            prev_stall = out_valid && !out_ready;
            if (m_kick) m_running = 1;
            m_kick = nk; m_dd = ndd;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        rst = 1; tick(); tick(); rst = 0;
    endtask

    task automatic do_load(input word_q_t vals, input bit toggle, input bit poke);
        int  i, guard;
        bit  ph, acc;
        i = 0; guard = 0; ph = 1;
        start_load = 1; tick(); start_load = 0;
        while (i < N && guard < 400) begin
            in_valid   = toggle ? ph : 1'b1;
            in_data    = in_valid ? vals[i] : $urandom;
            ph         = ~ph;
            core_done  = poke && (i == 5);
            start_load = poke && (i == 8);
            @(negedge clk);
            acc = in_valid && in_ready;
            tick();
            if (acc) i++;
            guard++;
        end
        in_valid = 0; core_done = 0; start_load = 0;
        if (i < N) chk("load_timeout", i, N);
    endtask

    task automatic run_drain(input int pct, input bit hold_done);
        int g;
        g = 0;
        got_q.delete(); acc_cyc.delete(); first_valid_cyc = -1;
        while (!ntt_start && g < 50) begin tick(); g++; end
        if (g >= 50) chk("kick_timeout", g, 0);
        tick(); tick();
        // core_done and start_load together in RUN: start_load must be dropped
        core_done = 1; start_load = 1;
        tick();
        start_load = 0;
        if (!hold_done) core_done = 0;
        ready_pct = pct;
        g = 0;
        while (busy && g < 600) begin tick(); g++; end
        if (g >= 600) chk("drain_timeout", g, 0);
        core_done = 0; ready_pct = 100;
        tick();
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        word_q_t v;
        int dd0;
        do_reset();
        chk_on = 1;
        // reset state
        chk("rst_in_ready", in_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ntt_start", ntt_start, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_range_err", range_err, 0);
        chk("rst_wr_en", mem_wr_en, 0);
        chk("rst_rd_en", mem_rd_en, 0);
        chk("rst_drain_done", drain_done, 0);

        // 1: stream 0..15, no stall, full-rate drain
        modulus = 17;
        v.delete(); for (int n = 0; n < N; n++) v.push_back(32'(n));
        kick_cnt = 0;
        do_load(v, 0, 0);
        chk("t1_mem_b1a1", env_mem[1*MA + 1], 5);
        chk("t1_mem_b3a3", env_mem[3*MA + 3], 15);
        chk("t1_range_err", range_err, 0);
        run_drain(100, 0);
        chk("t1_kick_cnt", kick_cnt, 1);
        chk("t1_out_cnt", got_q.size(), N);
        chk("t1_out1", got_q[1], 4);
        chk("t1_out4", got_q[4], 1);
        chk("t1_rate", acc_cyc[N-1] - acc_cyc[0], N - 1);
        chk("t1_latency", (first_valid_cyc - done_cyc) >= 3, 1);

        // 2: in_valid toggling, stray core_done/start_load during load
        v.delete(); for (int n = 0; n < N; n++) v.push_back($urandom_range(0, 16));
        wr_cnt = 0; kick_cnt = 0;
        do_load(v, 1, 1);
        chk("t2_wr_cnt", wr_cnt, N);
        run_drain(100, 0);
        chk("t2_kick_cnt", kick_cnt, 1);
        chk("t2_out_cnt", got_q.size(), N);

        // 3: range reduction and sticky range_err
        v.delete(); v.push_back(17); v.push_back(20); v.push_back(16);
        for (int n = 3; n < N; n++) v.push_back($urandom_range(0, 33));
        do_load(v, 0, 0);
        chk("t3_w0", env_mem[0*MA + 0], 0);
        chk("t3_w1", env_mem[1*MA + 0], 3);
        chk("t3_w2", env_mem[2*MA + 0], 16);
        chk("t3_range_err", range_err, 1);
        run_drain(70, 0);
        chk("t3_range_held", range_err, 1);
        do_reset();
        chk("t3_range_rst", range_err, 0);

        // 4: memory[b][a] = b*100+a, core_done held through drain
        modulus = 1000;
        v.delete(); for (int n = 0; n < N; n++) v.push_back(32'((n % BN)*100 + n / BN));
        do_load(v, 0, 0);
        run_drain(100, 1);
        chk("t4_out_cnt", got_q.size(), N);
        chk("t4_out0", got_q[0], 0);
        chk("t4_out3", got_q[3], 3);
        chk("t4_out4", got_q[4], 100);
        chk("t4_out15", got_q[15], 303);

        // 5: 30% out_ready back-pressure
        v.delete(); for (int n = 0; n < N; n++) v.push_back($urandom_range(0, 1999));
        dd0 = dd_cnt;
        do_load(v, 0, 0);
        run_drain(30, 0);
        chk("t5_out_cnt", got_q.size(), N);
        chk("t5_drain_done_cnt", dd_cnt - dd0, 1);
        chk("t5_busy", busy, 0);

        // 6: reset during load at n=7, then restart
        start_load = 1; tick(); start_load = 0;
        for (int n = 0; n < 7; n++) begin in_valid = 1; in_data = 32'(n); tick(); end
        in_data = 7; rst = 1; tick(); rst = 0;
        for (int k = 0; k < 3; k++) tick();
        chk("t6_in_ready", in_ready, 0);
        chk("t6_busy", busy, 0);
        in_valid = 0;
        v.delete(); for (int n = 0; n < N; n++) v.push_back(32'(500 + n));
        do_load(v, 0, 0);
        chk("t6_restart_b0a0", env_mem[0], 500);
        chk("t6_restart_b1a0", env_mem[1*MA + 0], 501);
        run_drain(100, 0);
        chk("t6_out_cnt", got_q.size(), N);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
